// File: rtl/bmem_read_assembler.sv
// ----------------------------------------------------------------------------
// bmem_read_assembler: tracks granted bmem reads in order and assembles the
// returned beats into cache lines for the instr or data cache.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bmem_read_assembler #(
  parameter int BURST_LEN = 4,
  parameter int TAG_DEPTH = 4,
  localparam int LINE_W = 64 * BURST_LEN,
  localparam int BW = $clog2(BURST_LEN),
  localparam int PW = $clog2(TAG_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_src,
  input  logic [31:0]       req_addr,
  output logic              req_ready,
  input  logic              bmem_rvalid,
  input  logic [31:0]       bmem_raddr,
  input  logic [63:0]       bmem_rdata,
  output logic              instr_line_valid,
  output logic [31:0]       instr_line_addr,
  output logic [LINE_W-1:0] instr_line_data,
  output logic              data_line_valid,
  output logic [31:0]       data_line_addr,
  output logic [LINE_W-1:0] data_line_data,
  output logic [CW-1:0]     outstanding,
  output logic              resp_err
);

  logic                       tag_src_q  [TAG_DEPTH];
  logic                       tag_src_d  [TAG_DEPTH];
  logic [31:0]                tag_addr_q [TAG_DEPTH];
  logic [31:0]                tag_addr_d [TAG_DEPTH];
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic [BW-1:0]              beat_q, beat_d;
  logic [BURST_LEN-1:0][63:0] buf_q, buf_d;
  logic                       instr_valid_q, instr_valid_d;
  logic [31:0]                instr_addr_q, instr_addr_d;
  logic [LINE_W-1:0]          instr_data_q, instr_data_d;
  logic                       data_valid_q, data_valid_d;
  logic [31:0]                data_addr_q, data_addr_d;
  logic [LINE_W-1:0]          data_data_q, data_data_d;
  logic                       err_q, err_d;

  logic        head_src;
  logic [31:0] head_addr;
  logic        empty, full, beat_acc, pop, push, addr_bad;

  always_comb begin
    head_src  = tag_src_q[rd_ptr_q];
    head_addr = tag_addr_q[rd_ptr_q];
    empty     = (count_q == '0);
    full      = (count_q == CW'(TAG_DEPTH));
    beat_acc  = bmem_rvalid & ~empty;
    pop       = beat_acc & (beat_q == BW'(BURST_LEN - 1));
    // A completing burst frees its slot in the same cycle, so a full FIFO can still accept.
    req_ready = ~full | pop;
    push      = req_valid & req_ready;
    addr_bad  = beat_acc & (beat_q == '0) & ((bmem_raddr & ~32'h1F) != head_addr);

    tag_src_d     = tag_src_q;
    tag_addr_d    = tag_addr_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q + CW'(push) - CW'(pop);
    beat_d        = beat_q;
    buf_d         = buf_q;
    instr_valid_d = 1'b0;
    instr_addr_d  = instr_addr_q;
    instr_data_d  = instr_data_q;
    data_valid_d  = 1'b0;
    data_addr_d   = data_addr_q;
    data_data_d   = data_data_q;
    err_d         = err_q | (req_valid & ~req_ready) | (bmem_rvalid & empty) | addr_bad;

    if (push) begin
      tag_src_d[wr_ptr_q]  = req_src;
      tag_addr_d[wr_ptr_q] = req_addr & ~32'h1F;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end

    if (beat_acc) begin
      buf_d[beat_q] = bmem_rdata;
      beat_d        = beat_q + BW'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (head_src) begin
        data_valid_d = 1'b1;
        data_addr_d  = head_addr;
        data_data_d  = buf_d;
      end else begin
        instr_valid_d = 1'b1;
        instr_addr_d  = head_addr;
        instr_data_d  = buf_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_src_q[i]  <= 1'b0;
        tag_addr_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      beat_q        <= '0;
      buf_q         <= '0;
      instr_valid_q <= 1'b0;
      instr_addr_q  <= '0;
      instr_data_q  <= '0;
      data_valid_q  <= 1'b0;
      data_addr_q   <= '0;
      data_data_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      tag_src_q     <= tag_src_d;
      tag_addr_q    <= tag_addr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      beat_q        <= beat_d;
      buf_q         <= buf_d;
      instr_valid_q <= instr_valid_d;
      instr_addr_q  <= instr_addr_d;
      instr_data_q  <= instr_data_d;
      data_valid_q  <= data_valid_d;
      data_addr_q   <= data_addr_d;
      data_data_q   <= data_data_d;
      err_q         <= err_d;
    end
  end

  assign instr_line_valid = instr_valid_q;
  assign instr_line_addr  = instr_addr_q;
  assign instr_line_data  = instr_data_q;
  assign data_line_valid  = data_valid_q;
  assign data_line_addr   = data_addr_q;
  assign data_line_data   = data_data_q;
  assign outstanding      = count_q;
  assign resp_err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bmem_read_assembler.sv
// ----------------------------------------------------------------------------
// tb_bmem_read_assembler: scoreboard bench for bmem_read_assembler.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bmem_read_assembler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_src = 1'b0;
  logic [31:0]  req_addr = '0;
  logic         req_ready;
  logic         bmem_rvalid = 1'b0;
  logic [31:0]  bmem_raddr = '0;
  logic [63:0]  bmem_rdata = '0;
  logic         instr_line_valid;
  logic [31:0]  instr_line_addr;
  logic [255:0] instr_line_data;
  logic         data_line_valid;
  logic [31:0]  data_line_addr;
  logic [255:0] data_line_data;
  logic [2:0]   outstanding;
  logic         resp_err;

  bmem_read_assembler #(.BURST_LEN(4), .TAG_DEPTH(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_src          (req_src),
    .req_addr         (req_addr),
    .req_ready        (req_ready),
    .bmem_rvalid      (bmem_rvalid),
    .bmem_raddr       (bmem_raddr),
    .bmem_rdata       (bmem_rdata),
    .instr_line_valid (instr_line_valid),
    .instr_line_addr  (instr_line_addr),
    .instr_line_data  (instr_line_data),
    .data_line_valid  (data_line_valid),
    .data_line_addr   (data_line_addr),
    .data_line_data   (data_line_data),
    .outstanding      (outstanding),
    .resp_err         (resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          src;
    logic [31:0] addr;
  } tag_t;

  typedef struct {
    bit           src;
    logic [31:0]  addr;
    logic [255:0] data;
    int           due;
  } line_t;

  tag_t   req_q[$];
  line_t  exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  int     m_beat = 0;
  int     exp_out = 0;
  bit     exp_err = 1'b0;
  bit     mon_en = 1'b0;
  logic [255:0] m_line = '0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_line(input bit src, input logic [31:0] addr, input logic [255:0] data);
    line_t e;
    if (exp_q.size() == 0) begin
      check("spurious_pulse", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("line_src", src, e.src);
      check("line_addr", addr, e.addr);
      check("line_data", data, e.data);
      check("line_latency", cyc, e.due);
    end
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (mon_en) begin
      check("outstanding", outstanding, exp_out);
      check("resp_err", resp_err, exp_err);
      if (instr_line_valid) chk_line(1'b0, instr_line_addr, instr_line_data);
      if (data_line_valid)  chk_line(1'b1, data_line_addr, data_line_data);
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        check("missing_pulse", 0, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  // One cycle of stimulus plus the reference model's view of that cycle.
  task automatic drive(input bit rv, input bit rs, input logic [31:0] ra,
                       input bit bv, input logic [31:0] ba, input logic [63:0] bd);
    bit    pop, rdy;
    tag_t  t;
    line_t l;
    @(negedge clk);
    req_valid = rv; req_src = rs; req_addr = ra;
    bmem_rvalid = bv; bmem_raddr = ba; bmem_rdata = bd;
    pop = 1'b0;
    if (bv) begin
      if (req_q.size() == 0) begin
        exp_err = 1'b1;
      end else begin
        if (m_beat == 0 && (ba & ~32'h1F) != req_q[0].addr) exp_err = 1'b1;
        m_line[m_beat*64 +: 64] = bd;
        if (m_beat == 3) begin
          l.src = req_q[0].src; l.addr = req_q[0].addr; l.data = m_line; l.due = cyc + 1;
          exp_q.push_back(l);
          pop = 1'b1;
        end
        m_beat = (m_beat + 1) % 4;
      end
    end
    rdy = (req_q.size() < 4) || pop;
    if (pop) void'(req_q.pop_front());
    if (rv) begin
      if (rdy) begin
        t.src = rs; t.addr = ra & ~32'h1F;
        req_q.push_back(t);
      end else begin
        exp_err = 1'b1;
      end
    end
    exp_out = req_q.size();
    #1 check("req_ready", req_ready, rdy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 32'h0, 0, 32'h0, 64'h0);
  endtask

  task automatic burst();
    logic [31:0] a;
    a = (req_q.size() > 0) ? req_q[0].addr : 32'h0;
    for (int i = 0; i < 4; i++) drive(0, 0, 32'h0, 1, a, {$urandom, $urandom});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b0; req_src = 1'b0; req_addr = '0;
    bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
    req_q.delete(); exp_q.delete();
    m_beat = 0; exp_out = 0; exp_err = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] a0, a1, a2, a3;
    logic [6:0]  gaps;
    a0 = 64'hA0A0_0000_0000_0000; a1 = 64'hA1A1_1111_1111_1111;
    a2 = 64'hA2A2_2222_2222_2222; a3 = 64'hA3A3_3333_3333_3333;

    @(posedge clk);
    #2 mon_en = 1'b1;
    do_reset();
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_instr_valid", instr_line_valid, 0);
    check("rst_instr_addr", instr_line_addr, 0);
    check("rst_instr_data", instr_line_data, 0);
    check("rst_data_valid", data_line_valid, 0);
    check("rst_data_addr", data_line_addr, 0);
    check("rst_data_data", data_line_data, 0);

    // Single instr line
    drive(1, 0, 32'h6000_0044, 0, 32'h0, 64'h0);
    drive(0, 0, 32'h0, 1, 32'h6000_0040, a0);
    drive(0, 0, 32'h0, 1, 32'h6000_0040, a1);
    drive(0, 0, 32'h0, 1, 32'h6000_0040, a2);
    drive(0, 0, 32'h0, 1, 32'h6000_0040, a3);
    idle(3);
    check("t1_addr", instr_line_addr, 32'h6000_0040);
    check("t1_data", instr_line_data, {a3, a2, a1, a0});
    check("t1_data_untouched", data_line_addr, 0);

    // Data then instr, back-to-back bursts
    drive(1, 1, 32'h8000_0100, 0, 32'h0, 64'h0);
    drive(1, 0, 32'h6000_0200, 0, 32'h0, 64'h0);
    burst();
    burst();
    idle(3);
    check("t2_data_addr", data_line_addr, 32'h8000_0100);
    check("t2_instr_addr", instr_line_addr, 32'h6000_0200);

    // Beats separated by idle gaps
    drive(1, 0, 32'h6000_0300, 0, 32'h0, 64'h0);
    gaps = 7'b1011001;
    for (int i = 0; i < 7; i++) begin
      if (gaps[i]) drive(0, 0, 32'h0, 1, 32'h6000_0300, {$urandom, $urandom});
      else         drive(0, 0, 32'h0, 0, 32'h0, 64'h0);
    end
    idle(3);

    // Fill the tag FIFO, overflow, then push while the head completes
    for (int i = 0; i < 4; i++) drive(1, i[0], 32'h7000_0000 + 32'(i) * 32'h20, 0, 32'h0, 64'h0);
    idle(1);
    check("full_ready", req_ready, 0);
    check("full_outstanding", outstanding, 4);
    drive(1, 1, 32'h7000_0800, 0, 32'h0, 64'h0);
    for (int i = 0; i < 3; i++) drive(0, 0, 32'h0, 1, 32'h7000_0000, {$urandom, $urandom});
    drive(1, 1, 32'h7000_0400, 1, 32'h7000_0000, {$urandom, $urandom});
    for (int i = 0; i < 4; i++) burst();
    idle(3);

    // Beat with nothing outstanding
    do_reset();
    drive(0, 0, 32'h0, 1, 32'h100, {$urandom, $urandom});
    idle(3);

    // First-beat address mismatch: error flagged, line still delivered
    do_reset();
    drive(1, 1, 32'h200, 0, 32'h0, 64'h0);
    for (int i = 0; i < 4; i++) drive(0, 0, 32'h0, 1, 32'h100, {$urandom, $urandom});
    idle(3);

    // Reset in the middle of a burst, then a clean burst
    do_reset();
    drive(1, 0, 32'h6000_0500, 0, 32'h0, 64'h0);
    drive(0, 0, 32'h0, 1, 32'h6000_0500, {$urandom, $urandom});
    drive(0, 0, 32'h0, 1, 32'h6000_0500, {$urandom, $urandom});
    do_reset();
    idle(2);
    drive(1, 0, 32'h6000_0600, 0, 32'h0, 64'h0);
    burst();
    idle(3);
    check("t6_addr", instr_line_addr, 32'h6000_0600);

    check("all_lines_seen", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
